// File: rtl/chirp_gen_param.sv
// Linear FM chirp generator: phase accumulator with a swept frequency word driving a
// cos/sin table. Supports up, down and triangle sweeps with repetition and abort.
module chirp_gen_param #(
   parameter int unsigned PHASE_W = 32,
   parameter int unsigned OUT_W   = 16,
   parameter int unsigned LUT_AW  = 10,
   parameter int unsigned CNT_W   = 32
) (
   input  logic                      CLOCK,
   input  logic                      RESETN,
   input  logic                      chirp_enable,
   input  logic                      chirp_init,
   output logic                      chirp_ready,
   output logic                      chirp_active,
   output logic                      chirp_done,
   output logic                      chirp_abort,
   input  logic [PHASE_W-1:0]        freq_offset_in,
   input  logic [PHASE_W-1:0]        tuning_word_coeff_in,
   input  logic [CNT_W-1:0]          chirp_count_max_in,
   input  logic [1:0]                mode_in,
   input  logic [7:0]                repeat_in,
   output logic signed [OUT_W-1:0]   IF_OUT_I,
   output logic signed [OUT_W-1:0]   IF_OUT_Q,
   output logic                      IF_OUT_VALID,
   output logic [PHASE_W-1:0]        CHIRP_FREQ
);

   localparam int unsigned LutSize = 1 << LUT_AW;
   localparam real         Pi      = 3.14159265358979323846;

   typedef enum logic [1:0] {StIdle, StUp, StDown} state_e;

   function automatic logic signed [OUT_W-1:0] trig_entry(input int unsigned idx,
                                                           input logic use_sin);
      real amp, ang, r;
      int  v;
      amp = real'((64'd1 << (OUT_W - 1)) - 64'd1);
      ang = 2.0 * Pi * real'(idx) / real'(LutSize);
      r   = use_sin ? amp * $sin(ang) : amp * $cos(ang);
      v   = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
      return OUT_W'(v);
   endfunction

   logic signed [OUT_W-1:0] cos_lut [LutSize];
   logic signed [OUT_W-1:0] sin_lut [LutSize];

   for (genvar g = 0; g < LutSize; g++) begin : g_lut
      assign cos_lut[g] = trig_entry(g, 1'b0);
      assign sin_lut[g] = trig_entry(g, 1'b1);
   end

   state_e               state_q, state_d;
   logic [PHASE_W-1:0]   freq_q, freq_d, phase_q, phase_d;
   logic [PHASE_W-1:0]   offset_q, offset_d, coeff_q, coeff_d;
   logic [CNT_W-1:0]     count_q, count_d, cmax_q, cmax_d;
   logic [7:0]           rep_q, rep_d, rep_max_q, rep_max_d;
   logic                 tri_q, tri_d, down_q, down_d;
   logic                 run_q;
   logic                 s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
   logic [LUT_AW-1:0]    s1_addr_q, s1_addr_d;
   logic [PHASE_W-1:0]   s1_freq_q, s1_freq_d;
   logic                 out_valid_d, done_d, abort_d;
   logic signed [OUT_W-1:0] out_i_d, out_q_d;
   logic [PHASE_W-1:0]   out_freq_d;
   logic                 start, flush;

   assign chirp_ready  = (state_q == StIdle) & chirp_enable & run_q;
   assign chirp_active = (state_q != StIdle);
   assign start        = chirp_ready & chirp_init;

   // Reset release is taken through one flop so the first edge after release only arms run_q.
   always_ff @(posedge CLOCK or negedge RESETN) begin
      if (!RESETN) run_q <= 1'b0;
      else         run_q <= 1'b1;
   end

   always_comb begin
      state_d    = state_q;
      freq_d     = freq_q;
      phase_d    = phase_q;
      count_d    = count_q;
      rep_d      = rep_q;
      offset_d   = offset_q;
      coeff_d    = coeff_q;
      cmax_d     = cmax_q;
      rep_max_d  = rep_max_q;
      tri_d      = tri_q;
      down_d     = down_q;
      s1_valid_d = 1'b0;
      s1_last_d  = 1'b0;
      s1_addr_d  = phase_q[PHASE_W-1 -: LUT_AW];
      s1_freq_d  = freq_q;
      abort_d    = 1'b0;
      flush      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               offset_d  = freq_offset_in;
               coeff_d   = tuning_word_coeff_in;
               cmax_d    = chirp_count_max_in;
               rep_max_d = (repeat_in == 8'd0) ? 8'd1 : repeat_in;
               tri_d     = (mode_in == 2'b10);
               down_d    = (mode_in == 2'b01);
               freq_d    = freq_offset_in;
               phase_d   = '0;
               count_d   = '0;
               rep_d     = '0;
               state_d   = (mode_in == 2'b01) ? StDown : StUp;
            end
         end
         StUp, StDown: begin
            if (!chirp_enable) begin
               state_d = StIdle;
               abort_d = 1'b1;
               flush   = 1'b1;
            end else begin
               s1_valid_d = 1'b1;
               phase_d    = phase_q + freq_q;
               freq_d     = (state_q == StUp) ? freq_q + coeff_q : freq_q - coeff_q;
               count_d    = count_q + CNT_W'(1);
               if (count_q == cmax_q) begin
                  count_d = '0;
                  if (state_q == StUp && tri_q) begin
                     state_d = StDown;
                  end else if (({1'b0, rep_q} + 9'd1) < {1'b0, rep_max_q}) begin
                     rep_d   = rep_q + 8'd1;
                     freq_d  = offset_q;
                     phase_d = '0;
                     state_d = down_q ? StDown : StUp;
                  end else begin
                     state_d   = StIdle;
                     s1_last_d = 1'b1;
                  end
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Output stage zeroes the sample whenever it is not qualified.
   always_comb begin
      out_valid_d = s1_valid_q & ~flush;
      done_d      = s1_valid_q & s1_last_q & ~flush;
      out_i_d     = out_valid_d ? cos_lut[s1_addr_q] : '0;
      out_q_d     = out_valid_d ? sin_lut[s1_addr_q] : '0;
      out_freq_d  = out_valid_d ? s1_freq_q : '0;
   end

   always_ff @(posedge CLOCK or negedge RESETN) begin
      if (!RESETN) begin
         state_q      <= StIdle;
         freq_q       <= '0;
         phase_q      <= '0;
         count_q      <= '0;
         rep_q        <= '0;
         offset_q     <= '0;
         coeff_q      <= '0;
         cmax_q       <= '0;
         rep_max_q    <= '0;
         tri_q        <= 1'b0;
         down_q       <= 1'b0;
         s1_valid_q   <= 1'b0;
         s1_last_q    <= 1'b0;
         s1_addr_q    <= '0;
         s1_freq_q    <= '0;
         IF_OUT_VALID <= 1'b0;
         IF_OUT_I     <= '0;
         IF_OUT_Q     <= '0;
         CHIRP_FREQ   <= '0;
         chirp_done   <= 1'b0;
         chirp_abort  <= 1'b0;
      end else begin
         state_q      <= state_d;
         freq_q       <= freq_d;
         phase_q      <= phase_d;
         count_q      <= count_d;
         rep_q        <= rep_d;
         offset_q     <= offset_d;
         coeff_q      <= coeff_d;
         cmax_q       <= cmax_d;
         rep_max_q    <= rep_max_d;
         tri_q        <= tri_d;
         down_q       <= down_d;
         s1_valid_q   <= s1_valid_d;
         s1_last_q    <= s1_last_d;
         s1_addr_q    <= s1_addr_d;
         s1_freq_q    <= s1_freq_d;
         IF_OUT_VALID <= out_valid_d;
         IF_OUT_I     <= out_i_d;
         IF_OUT_Q     <= out_q_d;
         CHIRP_FREQ   <= out_freq_d;
         chirp_done   <= done_d;
         chirp_abort  <= abort_d;
      end
   end

endmodule

// File: tb/tb_chirp_gen_param.sv
// Directed bench for chirp_gen_param: reset, up/down/triangle sweeps, LUT, repeat,
// abort/ignore, and frequency wrap with asynchronous reset.
module tb_chirp_gen_param;

   logic               clk, rst_n;
   logic               chirp_enable, chirp_init;
   logic               chirp_ready, chirp_active, chirp_done, chirp_abort;
   logic [31:0]        freq_offset_in, tuning_word_coeff_in, chirp_count_max_in;
   logic [1:0]         mode_in;
   logic [7:0]         repeat_in;
   logic signed [15:0] IF_OUT_I, IF_OUT_Q;
   logic               IF_OUT_VALID;
   logic [31:0]        CHIRP_FREQ;

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] freq_log[$];
   int          i_log[$];
   int          q_log[$];
   int          n_done, n_abort, done_idx, first_cyc, last_cyc;
   bit          act_gap;

   chirp_gen_param dut (
      .CLOCK               (clk),
      .RESETN              (rst_n),
      .chirp_enable        (chirp_enable),
      .chirp_init          (chirp_init),
      .chirp_ready         (chirp_ready),
      .chirp_active        (chirp_active),
      .chirp_done          (chirp_done),
      .chirp_abort         (chirp_abort),
      .freq_offset_in      (freq_offset_in),
      .tuning_word_coeff_in(tuning_word_coeff_in),
      .chirp_count_max_in  (chirp_count_max_in),
      .mode_in             (mode_in),
      .repeat_in           (repeat_in),
      .IF_OUT_I            (IF_OUT_I),
      .IF_OUT_Q            (IF_OUT_Q),
      .IF_OUT_VALID        (IF_OUT_VALID),
      .CHIRP_FREQ          (CHIRP_FREQ)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_chirp(input logic [31:0] off, input logic [31:0] coeff,
                              input logic [31:0] cmax, input logic [1:0] mode,
                              input logic [7:0] rep);
      freq_offset_in       = off;
      tuning_word_coeff_in = coeff;
      chirp_count_max_in   = cmax;
      mode_in              = mode;
      repeat_in            = rep;
      chirp_init           = 1'b1;
      tick();
      chirp_init           = 1'b0;
   endtask

   task automatic collect(input int budget);
      bit seen_inactive;
      freq_log.delete(); i_log.delete(); q_log.delete();
      n_done = 0; n_abort = 0; done_idx = -1; first_cyc = -1; last_cyc = -1;
      act_gap = 0; seen_inactive = 0;
      for (int c = 0; c < budget; c++) begin
         tick();
         if (IF_OUT_VALID) begin
            if (first_cyc < 0) first_cyc = c;
            last_cyc = c;
            freq_log.push_back(CHIRP_FREQ);
            i_log.push_back(int'(IF_OUT_I));
            q_log.push_back(int'(IF_OUT_Q));
         end
         if (chirp_done) begin
            n_done++;
            done_idx = IF_OUT_VALID ? freq_log.size() - 1 : -2;
         end
         if (chirp_abort) n_abort++;
         if (!chirp_active) seen_inactive = 1;
         else if (seen_inactive) act_gap = 1;
         if (first_cyc >= 0 && !IF_OUT_VALID && !chirp_active) break;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; chirp_enable = 1'b1; chirp_init = 1'b0;
      freq_offset_in = '0; tuning_word_coeff_in = '0; chirp_count_max_in = '0;
      mode_in = '0; repeat_in = '0;
      repeat (4) tick();
      n_checks++;
      if ({IF_OUT_VALID, IF_OUT_I, IF_OUT_Q, CHIRP_FREQ, chirp_active, chirp_done,
           chirp_abort, chirp_ready} !== '0)
         $display("FAIL reset_outputs: valid=%b i=%0d q=%0d f=%0h act=%b done=%b ab=%b rdy=%b want all 0",
                  IF_OUT_VALID, IF_OUT_I, IF_OUT_Q, CHIRP_FREQ, chirp_active, chirp_done,
                  chirp_abort, chirp_ready);
      else n_pass++;
      rst_n = 1'b1;
      tick();
      n_checks++;
      if (chirp_ready !== 1'b1 || chirp_active !== 1'b0)
         $display("FAIL reset_release_ready: ready=%b active=%b want 1/0", chirp_ready, chirp_active);
      else n_pass++;
   endtask

   task automatic test_up();
      int ferr, iqerr;
      start_chirp(32'd768, 32'd1, 32'd1023, 2'b00, 8'd1);
      collect(1200);
      n_checks++;
      if (freq_log.size() !== 1024)
         $display("FAIL up_count: got %0d want 1024", freq_log.size());
      else n_pass++;
      n_checks++;
      if (first_cyc !== 1) $display("FAIL up_latency: first valid tick %0d want 1", first_cyc);
      else n_pass++;
      if (freq_log.size() == 1024) begin
         ferr = 0; iqerr = 0;
         for (int k = 0; k < 1024; k++) begin
            if (freq_log[k] !== 32'(768 + k)) ferr++;
            if (i_log[k] != 32767 || q_log[k] != 0) iqerr++;
         end
         n_checks++;
         if (ferr != 0) $display("FAIL up_freq_seq: %0d wrong, want 0", ferr);
         else n_pass++;
         n_checks++;
         if (iqerr != 0 || i_log[0] != 32767)
            $display("FAIL up_iq: %0d wrong, first I=%0d Q=%0d want 32767/0", iqerr, i_log[0], q_log[0]);
         else n_pass++;
         n_checks++;
         if (freq_log[1023] !== 32'd1791) $display("FAIL up_last_freq: got %0d want 1791", freq_log[1023]);
         else n_pass++;
      end
      n_checks++;
      if (n_done != 1 || done_idx != 1023 || n_abort != 0)
         $display("FAIL up_done: dones=%0d at %0d aborts=%0d want 1 at 1023, 0", n_done, done_idx, n_abort);
      else n_pass++;
   endtask

   task automatic test_lut();
      int exp_i[4] = '{32767, 0, -32767, 0};
      int exp_q[4] = '{0, 32767, 0, -32767};
      start_chirp(32'h4000_0000, 32'd0, 32'd3, 2'b00, 8'd1);
      collect(20);
      n_checks++;
      if (freq_log.size() !== 4) $display("FAIL lut_count: got %0d want 4", freq_log.size());
      else n_pass++;
      for (int k = 0; k < 4 && k < freq_log.size(); k++) begin
         n_checks++;
         if (i_log[k] != exp_i[k] || q_log[k] != exp_q[k])
            $display("FAIL lut_quadrant%0d: I=%0d Q=%0d want %0d/%0d", k, i_log[k], q_log[k],
                     exp_i[k], exp_q[k]);
         else n_pass++;
      end
   endtask

   task automatic test_down_and_mode3();
      start_chirp(32'd768, 32'd1, 32'd3, 2'b01, 8'd0);
      collect(20);
      n_checks++;
      if (freq_log.size() !== 4 || freq_log[0] !== 32'd768 || freq_log[3] !== 32'd765 || n_done != 1)
         $display("FAIL down_sweep: n=%0d first=%0d last=%0d done=%0d want 4,768,765,1",
                  freq_log.size(), freq_log[0], freq_log[freq_log.size()-1], n_done);
      else n_pass++;
      start_chirp(32'd768, 32'd1, 32'd3, 2'b11, 8'd1);
      collect(20);
      n_checks++;
      if (freq_log.size() !== 4 || freq_log[3] !== 32'd771)
         $display("FAIL mode3_up: n=%0d last=%0d want 4,771", freq_log.size(),
                  freq_log[freq_log.size()-1]);
      else n_pass++;
   endtask

   task automatic test_triangle();
      int ferr;
      logic [31:0] e;
      start_chirp(32'd768, 32'd1, 32'd1023, 2'b10, 8'd1);
      collect(2300);
      n_checks++;
      if (freq_log.size() !== 2048) $display("FAIL tri_count: got %0d want 2048", freq_log.size());
      else n_pass++;
      if (freq_log.size() == 2048) begin
         ferr = 0;
         for (int k = 0; k < 2048; k++) begin
            e = (k < 1024) ? 32'(768 + k) : 32'(1792 - (k - 1024));
            if (freq_log[k] !== e) ferr++;
         end
         n_checks++;
         if (ferr != 0) $display("FAIL tri_freq_seq: %0d wrong, want 0", ferr);
         else n_pass++;
         n_checks++;
         if (freq_log[1023] !== 32'd1791 || freq_log[1024] !== 32'd1792 || freq_log[2047] !== 32'd769)
            $display("FAIL tri_turn: got %0d %0d %0d want 1791 1792 769",
                     freq_log[1023], freq_log[1024], freq_log[2047]);
         else n_pass++;
      end
      n_checks++;
      if (n_done != 1 || done_idx != 2047)
         $display("FAIL tri_done: dones=%0d at %0d want 1 at 2047", n_done, done_idx);
      else n_pass++;
   endtask

   task automatic test_repeat();
      int ferr;
      start_chirp(32'd768, 32'd1, 32'd15, 2'b00, 8'd3);
      collect(100);
      n_checks++;
      if (freq_log.size() !== 48 || last_cyc - first_cyc != 47)
         $display("FAIL rep_contig: n=%0d span=%0d want 48/47", freq_log.size(), last_cyc - first_cyc);
      else n_pass++;
      if (freq_log.size() == 48) begin
         ferr = 0;
         for (int k = 0; k < 48; k++) if (freq_log[k] !== 32'(768 + (k % 16))) ferr++;
         n_checks++;
         if (ferr != 0 || freq_log[16] !== 32'd768 || freq_log[32] !== 32'd768)
            $display("FAIL rep_freq: %0d wrong, f16=%0d f32=%0d want 0,768,768",
                     ferr, freq_log[16], freq_log[32]);
         else n_pass++;
      end
      n_checks++;
      if (act_gap || n_done != 1 || done_idx != 47)
         $display("FAIL rep_active_done: gap=%0d dones=%0d at %0d want 0,1 at 47", act_gap, n_done, done_idx);
      else n_pass++;
   endtask

   task automatic test_abort();
      int k, ferr, dn;
      k = 0; ferr = 0; dn = 0;
      start_chirp(32'd768, 32'd1, 32'd1023, 2'b00, 8'd1);
      for (int c = 0; c < 300; c++) begin
         tick();
         chirp_init = 1'b0;
         if (chirp_done) dn++;
         if (IF_OUT_VALID) begin
            if (CHIRP_FREQ !== 32'(768 + k)) ferr++;
            if (k == 50) begin
               chirp_init = 1'b1;
               freq_offset_in = 32'd5;
            end
            if (k == 100) begin
               chirp_enable = 1'b0;
               break;
            end
            k++;
         end
      end
      n_checks++;
      if (k != 100 || ferr != 0)
         $display("FAIL abort_ignore_init: reached %0d errors %0d want 100/0", k, ferr);
      else n_pass++;
      tick();
      n_checks++;
      if (chirp_abort !== 1'b1 || IF_OUT_VALID !== 1'b0 || chirp_done !== 1'b0 ||
          chirp_active !== 1'b0 || IF_OUT_I !== 16'sd0)
         $display("FAIL abort_pulse: abort=%b valid=%b done=%b active=%b I=%0d want 1,0,0,0,0",
                  chirp_abort, IF_OUT_VALID, chirp_done, chirp_active, IF_OUT_I);
      else n_pass++;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (chirp_done || IF_OUT_VALID || chirp_abort) dn++;
      end
      n_checks++;
      if (dn != 0 || chirp_ready !== 1'b0)
         $display("FAIL abort_after: stray events %0d ready=%b want 0/0", dn, chirp_ready);
      else n_pass++;
      chirp_enable = 1'b1;
      #1;
      n_checks++;
      if (chirp_ready !== 1'b1) $display("FAIL abort_ready_return: ready=%b want 1", chirp_ready);
      else n_pass++;
   endtask

   task automatic test_wrap();
      int nv, ev;
      start_chirp(32'hFFFF_FFFE, 32'd1, 32'd3, 2'b00, 8'd1);
      collect(20);
      n_checks++;
      if (freq_log.size() !== 4 || freq_log[0] !== 32'hFFFF_FFFE || freq_log[1] !== 32'hFFFF_FFFF ||
          freq_log[2] !== 32'h0 || freq_log[3] !== 32'h1 || n_done != 1)
         $display("FAIL wrap_freq: n=%0d f0=%0h f1=%0h f2=%0h f3=%0h done=%0d want 4 fffffffe ffffffff 0 1, 1",
                  freq_log.size(), freq_log[0], freq_log[1], freq_log[2], freq_log[3], n_done);
      else n_pass++;
      start_chirp(32'hFFFF_FFFE, 32'd1, 32'd3, 2'b00, 8'd1);
      nv = 0;
      for (int c = 0; c < 20 && nv < 3; c++) begin
         tick();
         if (IF_OUT_VALID) nv++;
      end
      n_checks++;
      if (nv != 3 || CHIRP_FREQ !== 32'h0) $display("FAIL wrap_sample2: n=%0d f=%0h want 3/0", nv, CHIRP_FREQ);
      else n_pass++;
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({IF_OUT_VALID, IF_OUT_I, IF_OUT_Q, CHIRP_FREQ, chirp_active, chirp_done, chirp_abort} !== '0)
         $display("FAIL wrap_async_reset: valid=%b i=%0d q=%0d f=%0h act=%b done=%b ab=%b want all 0",
                  IF_OUT_VALID, IF_OUT_I, IF_OUT_Q, CHIRP_FREQ, chirp_active, chirp_done, chirp_abort);
      else n_pass++;
      tick();
      rst_n = 1'b1;
      ev = 0;
      for (int c = 0; c < 5; c++) begin
         tick();
         if (IF_OUT_VALID || chirp_done || chirp_abort || chirp_active) ev++;
      end
      n_checks++;
      if (ev != 0 || chirp_ready !== 1'b1)
         $display("FAIL wrap_post_reset: stray events %0d ready=%b want 0/1", ev, chirp_ready);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_up();
      test_lut();
      test_down_and_mode3();
      test_triangle();
      test_repeat();
      test_abort();
      test_wrap();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
